// File: rtl/bridge_pkg.sv
// Shared drawbridge definitions: plant FSM state encodings and the sensor
// bit positions that the lifting controller also uses.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        PASS = 2'd2
    } ship_state_e;

    typedef enum logic {
        EMPTY = 1'b0,
        ON    = 1'b1
    } car_state_e;

    localparam int NUM_SENSORS = 6;
    localparam int S1_IDX = 0;
    localparam int S2_IDX = 1;
    localparam int S3_IDX = 2;
    localparam int S4_IDX = 3;
    localparam int S5_IDX = 4;
    localparam int S6_IDX = 5;

    // Width of a down-counter that has to hold the values 0 .. n-1
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/plant_tick_div.sv
// Prescaler for the plant: raises tick for one clock out of every TICK_DIV.
module plant_tick_div
    import bridge_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/bridge_plant_model.sv
// Drawbridge plant: turns the controller's actuator commands into sensor
// readings from a span position, a ship FSM and a vehicle FSM.
module bridge_plant_model
    import bridge_pkg::*;
#(
    parameter int TRAVEL_STEPS = 8,
    parameter int TICK_DIV     = 4,
    parameter int SHIP_LEN     = 3,
    parameter int CAR_LEN      = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                MT,
    input  logic                                AL,
    input  logic                                TFL,
    input  logic                                ship_req,
    input  logic                                car_req,
    output logic                                S1,
    output logic                                S2,
    output logic                                S3,
    output logic                                S4,
    output logic                                S5,
    output logic                                S6,
    output logic [$clog2(TRAVEL_STEPS+1)-1:0]   pos,
    output logic                                fault
);

    localparam int POS_W   = $clog2(TRAVEL_STEPS + 1);
    localparam int SHIP_CW = cnt_width(SHIP_LEN);
    localparam int CAR_CW  = cnt_width(CAR_LEN);

    localparam logic [POS_W-1:0]   POS_TOP   = POS_W'(TRAVEL_STEPS);
    localparam logic [SHIP_CW-1:0] SHIP_LAST = SHIP_CW'(SHIP_LEN - 1);
    localparam logic [CAR_CW-1:0]  CAR_LAST  = CAR_CW'(CAR_LEN - 1);

    logic                   tick;
    logic                   at_top;
    logic                   at_bottom;
    logic [POS_W-1:0]       pos_d;

    ship_state_e            ship_q, ship_d;
    logic                   pending_q, pending_d;
    logic [SHIP_CW-1:0]     ship_cnt_q, ship_cnt_d;

    car_state_e             car_q, car_d;
    logic [CAR_CW-1:0]      car_cnt_q, car_cnt_d;

    logic                   fault_set;
    logic [NUM_SENSORS-1:0] sens;

    // One saturating step of span travel; the counterweight lowers it when MT=0
    function automatic logic [POS_W-1:0] span_step(input logic [POS_W-1:0] p,
                                                   input logic             up);
        logic [POS_W-1:0] r;
        r = p;
        if (up) begin
            if (p != POS_TOP) r = p + 1'b1;
        end else begin
            if (p != '0) r = p - 1'b1;
        end
        return r;
    endfunction

    plant_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign at_top    = (pos == POS_TOP);
    assign at_bottom = (pos == '0);

    always_comb begin
        pos_d = pos;
        if (tick) pos_d = span_step(pos, MT);
    end

    // Ship arrival is not tick-gated; only passage progress follows the tick
    always_comb begin
        ship_d     = ship_q;
        pending_d  = pending_q;
        ship_cnt_d = ship_cnt_q;
        case (ship_q)
            IDLE: begin
                if (ship_req) ship_d = WAIT;
            end
            WAIT: begin
                if (ship_req) pending_d = 1'b1;
                if (tick && TFL && at_top) begin
                    ship_d     = PASS;
                    ship_cnt_d = SHIP_LAST;
                end
            end
            PASS: begin
                if (tick && (ship_cnt_q == '0)) begin
                    if (pending_q || ship_req) begin
                        ship_d    = WAIT;
                        pending_d = pending_q & ship_req;
                    end else begin
                        ship_d = IDLE;
                    end
                end else begin
                    if (tick) ship_cnt_d = ship_cnt_q - 1'b1;
                    if (ship_req) pending_d = 1'b1;
                end
            end
            default: begin
                ship_d    = IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // A vehicle is admitted against the pre-edge span position and alarm
    always_comb begin
        car_d     = car_q;
        car_cnt_d = car_cnt_q;
        case (car_q)
            EMPTY: begin
                if (car_req && at_bottom && !AL) begin
                    car_d     = ON;
                    car_cnt_d = CAR_LAST;
                end
            end
            ON: begin
                if (tick) begin
                    if (car_cnt_q == '0) car_d = EMPTY;
                    else                 car_cnt_d = car_cnt_q - 1'b1;
                end
            end
            default: car_d = EMPTY;
        endcase
    end

    always_comb begin
        fault_set = 1'b0;
        if (tick && !MT && !at_bottom && (ship_q == PASS)) fault_set = 1'b1;
        if (tick && MT && !at_top && (car_q == ON))        fault_set = 1'b1;
        if ((ship_q == PASS) && !at_top)                   fault_set = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos       <= '0;
            ship_q    <= IDLE;
            pending_q <= 1'b0;
            car_q     <= EMPTY;
            fault     <= 1'b0;
        end else begin
            pos       <= pos_d;
            ship_q    <= ship_d;
            pending_q <= pending_d;
            car_q     <= car_d;
            fault     <= fault | fault_set;
        end
    end

    // Occupancy counters are always loaded on FSM entry, so they need no reset
    always_ff @(posedge clk) begin
        ship_cnt_q <= ship_cnt_d;
        car_cnt_q  <= car_cnt_d;
    end

    always_comb begin
        sens         = '0;
        sens[S1_IDX] = (ship_q == WAIT);
        sens[S2_IDX] = (ship_q == PASS);
        sens[S3_IDX] = at_top;
        sens[S4_IDX] = at_bottom;
        sens[S5_IDX] = (car_q == ON);
        sens[S6_IDX] = (ship_q == IDLE);
    end

    assign S1 = sens[S1_IDX];
    assign S2 = sens[S2_IDX];
    assign S3 = sens[S3_IDX];
    assign S4 = sens[S4_IDX];
    assign S5 = sens[S5_IDX];
    assign S6 = sens[S6_IDX];

endmodule

// File: tb/tb_bridge_plant_model.sv
// Scoreboard bench for bridge_plant_model with TRAVEL_STEPS=4, TICK_DIV=2,
// SHIP_LEN=3, CAR_LEN=2; expected sensor vectors are listed as S1..S6.
module tb_bridge_plant_model;

    typedef struct packed {
        logic [5:0] s;
        logic [2:0] p;
        logic       f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       MT = 1'b0, AL = 1'b0, TFL = 1'b0;
    logic       ship_req = 1'b0, car_req = 1'b0;
    logic       S1, S2, S3, S4, S5, S6;
    logic [2:0] pos;
    logic       fault;

    exp_t  expq[$];
    string nameq[$];
    int    applied = 0;
    int    miscompares = 0;
    event  sample_ev;

    always #5 clk = ~clk;

    bridge_plant_model #(
        .TRAVEL_STEPS (4),
        .TICK_DIV     (2),
        .SHIP_LEN     (3),
        .CAR_LEN      (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MT       (MT),
        .AL       (AL),
        .TFL      (TFL),
        .ship_req (ship_req),
        .car_req  (car_req),
        .S1       (S1),
        .S2       (S2),
        .S3       (S3),
        .S4       (S4),
        .S5       (S5),
        .S6       (S6),
        .pos      (pos),
        .fault    (fault)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string nm, input logic [5:0] s,
                              input logic [2:0] p, input logic f);
        exp_t e;
        e.s = s;
        e.p = p;
        e.f = f;
        expq.push_back(e);
        nameq.push_back(nm);
        -> sample_ev;
        #1;
    endtask

    // Monitor: pops every queued expectation when a sample is presented
    initial begin
        exp_t  e;
        exp_t  act;
        string nm;
        forever begin
            @(sample_ev);
            while (expq.size() > 0) begin
                e   = expq.pop_front();
                nm  = nameq.pop_front();
                act.s = {S1, S2, S3, S4, S5, S6};
                act.p = pos;
                act.f = fault;
                applied++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL %s: got S1..S6=%b pos=%0d fault=%b, want S1..S6=%b pos=%0d fault=%b",
                             nm, act.s, act.p, act.f, e.s, e.p, e.f);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1);
    end

    initial begin
        step(2);
        expect_out("reset_state", 6'b000101, 3'd0, 1'b0);
        rst = 1'b0;
        MT  = 1'b1;

        step(1); expect_out("rise_k1",      6'b000101, 3'd0, 1'b0);
        step(1); expect_out("rise_s4_fall", 6'b000001, 3'd1, 1'b0);
        step(6); expect_out("rise_top",     6'b001001, 3'd4, 1'b0);
        step(2); expect_out("top_hold",     6'b001001, 3'd4, 1'b0);
        MT = 1'b0;
        step(1); expect_out("lower_start",  6'b001001, 3'd4, 1'b0);
        step(7); expect_out("lower_done",   6'b000101, 3'd0, 1'b0);
        ship_req = 1'b1;
        step(1); ship_req = 1'b0;
        expect_out("ship_wait",             6'b100100, 3'd0, 1'b0);
        step(4); expect_out("ship_wait_hold", 6'b100100, 3'd0, 1'b0);
        MT  = 1'b1;
        TFL = 1'b1;
        step(7); expect_out("ship_wait_top", 6'b101000, 3'd4, 1'b0);
        step(2); expect_out("ship_pass",     6'b011000, 3'd4, 1'b0);
        ship_req = 1'b1;
        step(1); ship_req = 1'b0;
        step(3); expect_out("pass_hold",       6'b011000, 3'd4, 1'b0);
        step(2); expect_out("pending_to_wait", 6'b101000, 3'd4, 1'b0);
        step(2); expect_out("second_pass",     6'b011000, 3'd4, 1'b0);
        MT = 1'b0;
        step(2); expect_out("lower_on_ship",   6'b010000, 3'd3, 1'b1);
        TFL = 1'b0;
        step(3); ship_req = 1'b1;
        step(1); ship_req = 1'b0;
        expect_out("req_at_complete",          6'b100000, 3'd1, 1'b1);
        step(2); expect_out("fault_sticky",    6'b100100, 3'd0, 1'b1);
        MT       = 1'b1;
        ship_req = 1'b1;
        step(1); ship_req = 1'b0;
        step(3); expect_out("mid_raise",       6'b100000, 3'd2, 1'b1);
        #1 rst = 1'b1;
        #1 expect_out("async_reset",           6'b000101, 3'd0, 1'b0);

        step(1);
        rst     = 1'b0;
        MT      = 1'b0;
        car_req = 1'b1;
        step(1); car_req = 1'b0;
        expect_out("car_on",                   6'b000111, 3'd0, 1'b0);
        step(2); expect_out("car_hold",        6'b000111, 3'd0, 1'b0);
        step(1); expect_out("car_leave",       6'b000101, 3'd0, 1'b0);
        car_req = 1'b1;
        step(1); car_req = 1'b0;
        expect_out("car_on2",                  6'b000111, 3'd0, 1'b0);
        MT = 1'b1;
        step(1); expect_out("raise_with_car",  6'b000011, 3'd1, 1'b1);
        step(2); expect_out("car_left_up",     6'b000001, 3'd2, 1'b1);
        car_req = 1'b1;
        MT      = 1'b0;
        step(1); car_req = 1'b0;
        expect_out("car_ign_pos",              6'b000001, 3'd2, 1'b1);
        step(3); expect_out("down_again",      6'b000101, 3'd0, 1'b1);
        car_req = 1'b1;
        AL      = 1'b1;
        step(1); car_req = 1'b0;
        expect_out("car_ign_al",               6'b000101, 3'd0, 1'b1);
        AL      = 1'b0;
        MT      = 1'b1;
        car_req = 1'b1;
        step(1); car_req = 1'b0;
        MT = 1'b0;
        expect_out("car_on_leave0",            6'b000011, 3'd1, 1'b1);
        step(4); expect_out("car_done",        6'b000101, 3'd0, 1'b1);

        ship_req = 1'b1;
        MT       = 1'b1;
        TFL      = 1'b1;
        step(1); ship_req = 1'b0;
        expect_out("wait_after_reset",         6'b100100, 3'd0, 1'b1);
        step(9); expect_out("pass_after_reset", 6'b011000, 3'd4, 1'b1);
        step(6); expect_out("idle_no_pending", 6'b001001, 3'd4, 1'b1);
        #1 rst = 1'b1;
        #1 expect_out("final_reset",           6'b000101, 3'd0, 1'b0);

        step(1);
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
